sha256_nonce_sweep: RTL and testbench



---
 rtl/sha256_nonce_sweep.sv | 236 +++++++++++++++++++++++
 tb/tb_sha256_nonce_sweep.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_nonce_sweep.sv
// rtl/sha256_nonce_sweep.sv - iterative double SHA-256 nonce sweep with streamed results
// Purpose: sweeps nonce_base_i .. nonce_base_i + nonce_count_i - 1 over a fixed
// block-1 midstate. Each nonce is hashed twice on one shared round engine, and
// the first word of the second digest is streamed out with valid/ready.
// Ports:
//   clk_i, reset_i     : clock, asynchronous active-high reset
//   start_i            : one-cycle sweep request, sampled only in IDLE
//   midstate_i         : h0..h7 after header block 1 (h0 in [255:224])
//   tail_i             : header words 16..18 (word 16 in [95:64])
//   nonce_base_i       : first nonce of the sweep
//   nonce_count_i      : number of nonces to process (0..MAX_NONCES)
//   target_i           : hit threshold on final digest word 0
//   busy_o, done_o     : sweep in progress / one-cycle end-of-sweep pulse
//   out_valid_o/out_ready_i, out_nonce_o, out_h0_o, out_hit_o : result stream
module sha256_nonce_sweep #(
  parameter int MAX_NONCES  = 16,
  parameter int STOP_ON_HIT = 0,
  parameter int CNT_W       = $clog2(MAX_NONCES + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [255:0]     midstate_i,
  input  logic [95:0]      tail_i,
  input  logic [31:0]      nonce_base_i,
  input  logic [CNT_W-1:0] nonce_count_i,
  input  logic [31:0]      target_i,
  output logic             busy_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_nonce_o,
  output logic [31:0]      out_h0_o,
  output logic             out_hit_o,
  output logic             done_o
);

  typedef enum logic [3:0] {
    IDLE, LOAD1, RND1, FIN1, LOAD2, RND2, FIN2, EMIT, DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_at(input logic [5:0] idx);
    logic [31:0] k;
    k = 32'h0;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  state_t           state_q;
  logic [255:0]     mid_q;
  logic [95:0]      tail_q;
  logic [31:0]      target_q;
  logic [31:0]      nonce_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] proc_q;
  logic [5:0]       rnd_q;
  logic [31:0]      hv_q [8];
  logic [31:0]      w_q  [16];

  logic             busy_q;
  logic             out_valid_q;
  logic [31:0]      out_nonce_q;
  logic [31:0]      out_h0_q;
  logic             out_hit_q;
  logic             done_q;

  logic [31:0]      ch_d, maj_d, t1_d, t2_d, w_new_d, h0_d;
  logic             hit_d;

  // One SHA-256 round on A..H (hv_q[0..7]); w_q[0] always holds w[t] and
  // w_new_d is w[t+16], pushed into the top of the 16-word window.
  always_comb begin
    ch_d    = (hv_q[4] & hv_q[5]) ^ (~hv_q[4] & hv_q[6]);
    maj_d   = (hv_q[0] & hv_q[1]) ^ (hv_q[0] & hv_q[2]) ^ (hv_q[1] & hv_q[2]);
    t1_d    = hv_q[7] + bsig1(hv_q[4]) + ch_d + k_at(rnd_q) + w_q[0];
    t2_d    = bsig0(hv_q[0]) + maj_d;
    w_new_d = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    h0_d    = IV[0] + hv_q[0];
    hit_d   = h0_d < target_q;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      mid_q       <= '0;
      tail_q      <= '0;
      target_q    <= '0;
      nonce_q     <= '0;
      count_q     <= '0;
      proc_q      <= '0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_nonce_q <= '0;
      out_h0_q    <= '0;
      out_hit_q   <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 8; i++) hv_q[i] <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mid_q    <= midstate_i;
            tail_q   <= tail_i;
            target_q <= target_i;
            nonce_q  <= nonce_base_i;
            count_q  <= nonce_count_i;
            proc_q   <= '0;
            if (nonce_count_i == '0) begin
              state_q <= DONE;
            end else begin
              busy_q  <= 1'b1;
              state_q <= LOAD1;
            end
          end
        end
        LOAD1: begin
          for (int i = 0; i < 8; i++) hv_q[i] <= mid_q[255 - 32*i -: 32];
          for (int i = 0; i < 3; i++) w_q[i] <= tail_q[95 - 32*i -: 32];
          w_q[3] <= nonce_q;
          w_q[4] <= 32'h80000000;
          for (int i = 5; i < 15; i++) w_q[i] <= '0;
          w_q[15] <= 32'd640;
          rnd_q   <= '0;
          state_q <= RND1;
        end
        RND1, RND2: begin
          hv_q[0] <= t1_d + t2_d;
          hv_q[1] <= hv_q[0];
          hv_q[2] <= hv_q[1];
          hv_q[3] <= hv_q[2];
          hv_q[4] <= hv_q[3] + t1_d;
          hv_q[5] <= hv_q[4];
          hv_q[6] <= hv_q[5];
          hv_q[7] <= hv_q[6];
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new_d;
          rnd_q   <= rnd_q + 6'd1;
          if (rnd_q == 6'd63) state_q <= (state_q == RND1) ? FIN1 : FIN2;
        end
        FIN1: begin
          // First digest lands directly in the message window for block 2.
          for (int i = 0; i < 8; i++) w_q[i] <= mid_q[255 - 32*i -: 32] + hv_q[i];
          state_q <= LOAD2;
        end
        LOAD2: begin
          for (int i = 0; i < 8; i++) hv_q[i] <= IV[i];
          w_q[8] <= 32'h80000000;
          for (int i = 9; i < 15; i++) w_q[i] <= '0;
          w_q[15] <= 32'd256;
          rnd_q   <= '0;
          state_q <= RND2;
        end
        FIN2: begin
          out_h0_q    <= h0_d;
          out_hit_q   <= hit_d;
          out_nonce_q <= nonce_q;
          out_valid_q <= 1'b1;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            nonce_q     <= nonce_q + 32'd1;
            proc_q      <= proc_q + CNT_ONE;
            if ((proc_q + CNT_ONE == count_q) || ((STOP_ON_HIT != 0) && out_hit_q)) begin
              state_q <= DONE;
            end else begin
              state_q <= LOAD1;
            end
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign out_valid_o = out_valid_q;
  assign out_nonce_o = out_nonce_q;
  assign out_h0_o    = out_h0_q;
  assign out_hit_o   = out_hit_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_sha256_nonce_sweep.sv
// tb/tb_sha256_nonce_sweep.sv - scoreboard bench for sha256_nonce_sweep
module tb_sha256_nonce_sweep;

  localparam int MAXN = 16;
  localparam int CW   = $clog2(MAXN + 1);

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV256 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start [2];
  logic [255:0]   midstate;
  logic [95:0]    tail;
  logic [31:0]    nonce_base;
  logic [CW-1:0]  nonce_count;
  logic [31:0]    target;
  logic           out_ready;
  logic           busy [2], out_valid [2], out_hit [2], done [2];
  logic [31:0]    out_nonce [2], out_h0 [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sha256_nonce_sweep #(.MAX_NONCES(MAXN), .STOP_ON_HIT(g)) u_dut (
      .clk_i(clk), .reset_i(reset), .start_i(start[g]),
      .midstate_i(midstate), .tail_i(tail), .nonce_base_i(nonce_base),
      .nonce_count_i(nonce_count), .target_i(target),
      .busy_o(busy[g]), .out_valid_o(out_valid[g]), .out_ready_i(out_ready),
      .out_nonce_o(out_nonce[g]), .out_h0_o(out_h0[g]), .out_hit_o(out_hit[g]),
      .done_o(done[g])
    );
  end

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] h0;
    logic        hit;
  } res_t;

  res_t exp_q [$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   sel = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;
  int   exp_rise = 0;
  int   n_acc = 0;
  int   last_acc = 0;
  bit   have_snap = 0;
  logic [64:0] snap;
  res_t got_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  function automatic logic [31:0] model_h0(input logic [255:0] m, input logic [95:0] tl, input logic [31:0] n);
    logic [255:0] d1, d2;
    d1 = compress(m, {tl, n, 32'h80000000, 320'd0, 32'd640});
    d2 = compress(IV256, {d1, 32'h80000000, 192'd0, 32'd256});
    return d2[255:224];
  endfunction

  function automatic logic [255:0] r256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // ---------------- cycle counter and ready driver ----------------
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        if (out_valid[sel] && stall_cnt < 20) begin
          out_ready = 1'b0;
          stall_cnt++;
        end else if (out_valid[sel]) begin
          out_ready = 1'b1;
        end else begin
          out_ready = 1'b0;
          stall_cnt = 0;
        end
      end
    endcase
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset) begin
      have_snap = 0;
    end else if (out_valid[sel]) begin
      if (!have_snap) begin
        check("valid_rise_cycle", cyc, exp_rise);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_result: got nonce %0h, want no result", out_nonce[sel]);
        end else begin
          got_e = exp_q.pop_front();
          check("out_nonce", out_nonce[sel], got_e.nonce);
          check("out_h0", out_h0[sel], got_e.h0);
          check("out_hit", out_hit[sel], got_e.hit);
        end
        snap = {out_nonce[sel], out_h0[sel], out_hit[sel]};
        have_snap = 1;
      end else begin
        check("payload_stable", {out_nonce[sel], out_h0[sel], out_hit[sel]}, snap);
      end
      if (out_ready) begin
        have_snap = 0;
        n_acc++;
        last_acc = cyc + 1;
        exp_rise = cyc + 1 + 132;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_sweep(input int s, input logic [255:0] m, input logic [95:0] tl,
                           input logic [31:0] base, input int cnt, input logic [31:0] tgt,
                           input int rmode);
    int   n_exp, acc0, start_edge, waited, limit;
    res_t r;
    @(posedge clk);
    #1;
    sel = s;
    ready_mode = rmode;
    midstate = m;
    tail = tl;
    nonce_base = base;
    nonce_count = cnt[CW-1:0];
    target = tgt;
    exp_q.delete();
    n_exp = 0;
    for (int i = 0; i < cnt; i++) begin
      r.nonce = base + i;
      r.h0 = model_h0(m, tl, r.nonce);
      r.hit = r.h0 < tgt;
      exp_q.push_back(r);
      n_exp++;
      if (s == 1 && r.hit) break;
    end
    acc0 = n_acc;
    start[s] = 1'b1;
    @(posedge clk);
    #1;
    start_edge = cyc;
    exp_rise = start_edge + 132;
    start[s] = 1'b0;
    // latched inputs must not be re-sampled mid-sweep
    midstate = r256();
    tail = r256()[95:0];
    nonce_base = $urandom();
    target = $urandom();
    check("busy_after_start", busy[s], (cnt != 0));
    limit = (cnt + 1) * 200 + 100;
    waited = 0;
    while (!done[s] && waited < limit) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!done[s]) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", waited);
    end else begin
      check("done_cycle", cyc, (n_exp > 0) ? last_acc + 1 : start_edge + 1);
      check("result_count", n_acc - acc0, n_exp);
      check("queue_empty", exp_q.size(), 0);
      check("busy_at_done", busy[s], 0);
      @(posedge clk);
      #1;
      check("done_one_cycle", done[s], 0);
    end
  endtask

  initial begin : stim
    logic [255:0] m;
    logic [95:0]  tl;
    logic [31:0]  h [3];
    logic [31:0]  tgt;
    logic [255:0] kat;
    logic         seen_done;
    start[0] = 1'b0;
    start[1] = 1'b0;
    midstate = '0;
    tail = '0;
    nonce_base = '0;
    nonce_count = '0;
    target = '0;
    out_ready = 1'b1;

    // model sanity: SHA-256("abc")
    kat = compress(IV256, {32'h61626380, 448'd0, 32'h00000018});
    check("model_abc_w0", kat[255:224], 32'hba7816bf);
    check("model_abc_w7", kat[31:0], 32'hf20015ad);

    repeat (3) @(posedge clk);
    #1;
    for (int g = 0; g < 2; g++) begin
      check("reset_outputs", {busy[g], out_valid[g], done[g], out_hit[g], out_nonce[g], out_h0[g]}, 0);
    end
    reset = 1'b0;

    // single nonce, target 0: no hit
    run_sweep(0, r256(), r256()[95:0], 32'h0, 1, 32'h0, 0);
    // four nonces, all-ones target, ready held high
    run_sweep(0, r256(), r256()[95:0], 32'h0, 4, 32'hFFFFFFFF, 0);

    // stop-on-hit: pick a midstate whose nonce 2 is strictly the smallest
    m = r256();
    tl = r256()[95:0];
    for (int t = 0; t < 50; t++) begin
      m = r256();
      tl = r256()[95:0];
      for (int i = 0; i < 3; i++) h[i] = model_h0(m, tl, i);
      if (h[2] < h[0] && h[2] < h[1]) break;
    end
    tgt = h[2] + 32'd1;
    run_sweep(1, m, tl, 32'h0, 8, tgt, 0);
    // stop-on-hit instance with no hits runs the full count
    run_sweep(1, r256(), r256()[95:0], 32'h10, 2, 32'h0, 0);

    // 20-cycle backpressure stall per result
    run_sweep(0, r256(), r256()[95:0], $urandom(), 3, $urandom(), 2);
    // nonce wrap
    run_sweep(0, r256(), r256()[95:0], 32'hFFFFFFFE, 3, $urandom(), 0);
    // empty sweep
    run_sweep(0, r256(), r256()[95:0], 32'h5, 0, $urandom(), 0);

    // reset in the middle of a sweep
    @(posedge clk);
    #1;
    sel = 0;
    ready_mode = 0;
    exp_q.delete();
    midstate = r256();
    nonce_count = 4;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (69) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_busy", busy[0], 0);
    check("reset_mid_valid", out_valid[0], 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      seen_done = seen_done | done[0] | out_valid[0];
    end
    check("reset_mid_no_done", seen_done, 0);
    run_sweep(0, r256(), r256()[95:0], 32'h1234, 2, 32'h80000000, 0);

    // randomized sweeps with random backpressure
    for (int i = 0; i < 4; i++) begin
      run_sweep($urandom_range(0, 1), r256(), r256()[95:0], $urandom(),
                $urandom_range(1, 4), $urandom(), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1);
  end

endmodule
